// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS-style datapath.
// Control outputs are registered from the next state; only the FETCH write strobes are gated by mem_ready.
module multicycle_control #(
    parameter int OP_W      = 6,
    parameter bit USE_READY = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OP_W-1:0] op,
    input  logic            mem_ready,
    output logic            pc_write,
    output logic            pc_write_cond,
    output logic            iord,
    output logic            mem_read,
    output logic            mem_write,
    output logic            ir_write,
    output logic            mem_to_reg,
    output logic            reg_dst,
    output logic            reg_write,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      alu_op,
    output logic [1:0]      pc_source,
    output logic            illegal_op,
    output logic [3:0]      state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  RWB    = 4'd7,
        BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'h00);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'h02);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'h04);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'h08);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'h23);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'h2B);

    // Bit positions inside the packed control word
    localparam int B_PCW  = 15;
    localparam int B_PCWC = 14;
    localparam int B_IORD = 13;
    localparam int B_MRD  = 12;
    localparam int B_MWR  = 11;
    localparam int B_IRW  = 10;
    localparam int B_M2R  = 9;
    localparam int B_RDST = 8;
    localparam int B_RW   = 7;
    localparam int B_ASA  = 6;
    localparam int B_ASB  = 4;
    localparam int B_AOP  = 2;
    localparam int B_PCS  = 0;

    function automatic logic [15:0] ctrl_of(input state_t s);
        logic [15:0] c;
        c = 16'h0000;
        case (s)
            FETCH: begin
                c[B_MRD] = 1'b1; c[B_IRW] = 1'b1; c[B_PCW] = 1'b1;
                c[B_ASB +: 2] = 2'b01;
            end
            DECODE: c[B_ASB +: 2] = 2'b11;
            MEMADR, ADDIEX: begin
                c[B_ASA] = 1'b1; c[B_ASB +: 2] = 2'b10;
            end
            MEMRD:  begin c[B_MRD] = 1'b1; c[B_IORD] = 1'b1; end
            MEMWB:  begin c[B_RW] = 1'b1;  c[B_M2R] = 1'b1;  end
            MEMWR:  begin c[B_MWR] = 1'b1; c[B_IORD] = 1'b1; end
            EXEC:   begin c[B_ASA] = 1'b1; c[B_AOP +: 2] = 2'b10; end
            RWB:    begin c[B_RW] = 1'b1;  c[B_RDST] = 1'b1; end
            BRANCH: begin
                c[B_ASA] = 1'b1; c[B_AOP +: 2] = 2'b01;
                c[B_PCWC] = 1'b1; c[B_PCS +: 2] = 2'b01;
            end
            ADDIWB: c[B_RW] = 1'b1;
            JUMP:   begin c[B_PCW] = 1'b1; c[B_PCS +: 2] = 2'b10; end
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

    state_t      state_r;
    state_t      next_s;
    logic        hold_r;
    logic [15:0] ctrl_r;
    logic        ready_s;
    logic        op_known_s;
    logic        stall_s;

    assign ready_s    = USE_READY ? mem_ready : 1'b1;
    assign op_known_s = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
                        (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);

    // Next-state decode; hold_r keeps the first cycle after reset as a quiet FETCH
    always_comb begin
        next_s = FETCH;
        if (hold_r) begin
            next_s = FETCH;
        end else begin
            case (state_r)
                FETCH:  next_s = ready_s ? DECODE : FETCH;
                DECODE: begin
                    if ((op == OP_LW) || (op == OP_SW)) next_s = MEMADR;
                    else if (op == OP_RTYPE)            next_s = EXEC;
                    else if (op == OP_BEQ)              next_s = BRANCH;
                    else if (op == OP_ADDI)             next_s = ADDIEX;
                    else if (op == OP_J)                next_s = JUMP;
                    else                                next_s = FETCH;
                end
                MEMADR: next_s = (op == OP_SW) ? MEMWR : MEMRD;
                MEMRD:  next_s = ready_s ? MEMWB : MEMRD;
                MEMWR:  next_s = ready_s ? FETCH : MEMWR;
                EXEC:   next_s = RWB;
                ADDIEX: next_s = ADDIWB;
                default: next_s = FETCH;
            endcase
        end
    end

    // State and control-word registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= FETCH;
            hold_r  <= 1'b1;
            ctrl_r  <= 16'h0000;
        end else begin
            state_r <= next_s;
            hold_r  <= 1'b0;
            ctrl_r  <= ctrl_of(next_s);
        end
    end

    // FETCH write strobes fire only in the cycle the memory delivers
    assign stall_s = (state_r == FETCH) && !ready_s;

    assign pc_write      = ctrl_r[B_PCW] & ~stall_s;
    assign ir_write      = ctrl_r[B_IRW] & ~stall_s;
    assign pc_write_cond = ctrl_r[B_PCWC];
    assign iord          = ctrl_r[B_IORD];
    assign mem_read      = ctrl_r[B_MRD];
    assign mem_write     = ctrl_r[B_MWR];
    assign mem_to_reg    = ctrl_r[B_M2R];
    assign reg_dst       = ctrl_r[B_RDST];
    assign reg_write     = ctrl_r[B_RW];
    assign alu_src_a     = ctrl_r[B_ASA];
    assign alu_src_b     = ctrl_r[B_ASB +: 2];
    assign alu_op        = ctrl_r[B_AOP +: 2];
    assign pc_source     = ctrl_r[B_PCS +: 2];
    assign illegal_op    = (state_r == DECODE) && !op_known_s;
    assign state         = state_r;

endmodule
